// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port handshake between the control FSM and the memory.
// The controller drives the request side and the memory answers with mem_ready.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared memory port, ALU and register file,
// decodes the instruction type into registered one-hot flags and traps on illegal/timeout.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master mem,
   input  logic [31:0]       instr,
   input  logic              branch_taken,
   output logic [2:0]        state,
   output logic              ir_we,
   output logic              pc_we,
   output logic [1:0]        pc_sel,
   output logic              reg_we,
   output logic [1:0]        wb_sel,
   output logic              isLUI,
   output logic              isAUIPC,
   output logic              isJAL,
   output logic              isJALR,
   output logic              isBranch,
   output logic              isLoad,
   output logic              isStore,
   output logic              isALUimm,
   output logic              isALU,
   output logic              retire,
   output logic              trap,
   output logic [1:0]        trap_cause
);

   typedef enum logic [2:0] {
      StBoot   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   localparam int unsigned FlLui    = 8;
   localparam int unsigned FlAuipc  = 7;
   localparam int unsigned FlJal    = 6;
   localparam int unsigned FlJalr   = 5;
   localparam int unsigned FlBranch = 4;
   localparam int unsigned FlLoad   = 3;
   localparam int unsigned FlStore  = 2;
   localparam int unsigned FlAluImm = 1;
   localparam int unsigned FlAlu    = 0;

   // Wide enough to hold TIMEOUT_CYCLES-1, the last waiting count before the trap.
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e            state_q, state_d;
   logic [8:0]        flags_q, flags_d;
   logic [1:0]        cause_q, cause_d;
   logic [CntW-1:0]   wait_q, wait_d;

   logic [8:0]        dec;
   logic              illegal;
   logic              timeout;
   logic              mem_req, mem_we, mem_addr_sel;
   logic              unused_instr;

   assign unused_instr = ^instr[31:12];

   always_comb begin
      dec     = '0;
      illegal = 1'b0;
      unique case (instr[6:0])
         7'b0110111: dec[FlLui]    = 1'b1;
         7'b0010111: dec[FlAuipc]  = 1'b1;
         7'b1101111: dec[FlJal]    = 1'b1;
         7'b1100111: dec[FlJalr]   = 1'b1;
         7'b1100011: dec[FlBranch] = 1'b1;
         7'b0000011: dec[FlLoad]   = 1'b1;
         7'b0100011: dec[FlStore]  = 1'b1;
         7'b0010011: dec[FlAluImm] = 1'b1;
         7'b0110011: dec[FlAlu]    = 1'b1;
         7'b0001111: dec           = '0;
         default:    illegal       = 1'b1;
      endcase
   end

   assign timeout = (TIMEOUT_CYCLES != 0) && (32'(wait_q) == TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d      = state_q;
      flags_d      = flags_q;
      cause_d      = cause_q;
      wait_d       = '0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;

      unique case (state_q)
         StBoot: state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            if (mem.mem_ready) begin
               ir_we   = 1'b1;
               state_d = StDecode;
            end else if (timeout) begin
               state_d = StTrap;
               cause_d = 2'd2;
            end else begin
               wait_d = CntW'(wait_q + 1'b1);
            end
         end
         StDecode: begin
            flags_d = dec;
            if (illegal && TRAP_ON_ILLEGAL) begin
               state_d = StTrap;
               cause_d = 2'd1;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (flags_q[FlLoad] || flags_q[FlStore]) begin
               state_d = StMem;
            end else if (flags_q[FlBranch] || flags_q == '0) begin
               // Branches and NOPs finish here without a writeback cycle.
               pc_we   = 1'b1;
               pc_sel  = {1'b0, flags_q[FlBranch] & branch_taken};
               retire  = 1'b1;
               state_d = StFetch;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = flags_q[FlStore];
            if (mem.mem_ready) begin
               if (flags_q[FlStore]) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (timeout) begin
               state_d = StTrap;
               cause_d = 2'd2;
            end else begin
               wait_d = CntW'(wait_q + 1'b1);
            end
         end
         StWb: begin
            reg_we  = |instr[11:7];
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
            if (flags_q[FlLoad]) begin
               wb_sel = 2'd1;
            end else if (flags_q[FlJal] || flags_q[FlJalr]) begin
               wb_sel = 2'd2;
            end else if (flags_q[FlLui]) begin
               wb_sel = 2'd3;
            end
            if (flags_q[FlJal]) begin
               pc_sel = 2'd1;
            end else if (flags_q[FlJalr]) begin
               pc_sel = 2'd2;
            end
         end
         StTrap: state_d = StTrap;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StBoot;
         flags_q <= '0;
         cause_q <= 2'd0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cause_q <= cause_d;
         wait_q  <= wait_d;
      end
   end

   assign state            = state_q;
   assign trap             = (state_q == StTrap);
   assign trap_cause       = cause_q;
   assign mem.mem_req      = mem_req;
   assign mem.mem_we       = mem_we;
   assign mem.mem_addr_sel = mem_addr_sel;
   assign {isLUI, isAUIPC, isJAL, isJALR, isBranch, isLoad, isStore, isALUimm, isALU} = flags_q;

endmodule
